// File: rtl/audio_dac_multibit.sv
// Multi-channel first-order delta-sigma DAC: PCM handshake, gain shift, C_out_width-bit noise shaping.
// Optional AUDIO_DAC_DITHER_EN adds 16-bit LFSR dither ahead of the quantiser.
module audio_dac_multibit #(
  parameter int unsigned C_channels   = 2,
  parameter int unsigned C_in_width   = 16,
  parameter int unsigned C_out_width  = 4,
  parameter int unsigned C_gain_shift = 0,
  parameter int unsigned C_div        = 256
) (
  input  logic                                clk_audio,
  input  logic                                reset,
  input  logic [C_channels*C_in_width-1:0]    in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                sample_tick,
  output logic                                underrun,
  input  logic                                clear_underrun,
  output logic [C_channels*C_out_width-1:0]   dac_out
);

  localparam int unsigned W    = C_in_width;
  localparam int unsigned Cw   = C_out_width;
  localparam int unsigned F    = W - Cw;
  localparam int unsigned GW   = W + 4;
  localparam int unsigned CntW = $clog2(C_div);

  localparam logic [CntW-1:0]      CntLast = CntW'(C_div - 1);
  localparam logic [Cw-1:0]        Mid     = Cw'(1) << (Cw - 1);
  localparam logic signed [GW-1:0] SatMax  = {{(GW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [GW-1:0] SatMin  = {{(GW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          tick, xfer;
  logic                          in_ready_q, in_ready_d;
  logic                          pend_full_q, pend_full_d;
  logic                          sample_tick_q, sample_tick_d;
  logic                          underrun_q, underrun_d;
  logic [C_channels*W-1:0]       pend_q, pend_d;
  logic [C_channels*W-1:0]       active_q, active_d;
  logic [C_channels-1:0][F-1:0]  err_q, err_d;
  logic [C_channels*Cw-1:0]      dac_q, dac_d;
  logic [F-1:0]                  dith;

  logic [C_channels-1:0][GW-1:0] shifted;
  logic [C_channels-1:0][W-1:0]  g_w, u;
  logic [C_channels-1:0][W:0]    sum;
  logic [C_channels-1:0][Cw:0]   q_raw;

`ifdef AUDIO_DAC_DITHER_EN
  localparam int unsigned   DitW    = (F > 2) ? (((F - 2) > 16) ? 16 : (F - 2)) : 0;
  localparam logic [15:0]   DitMask = 16'((32'd1 << DitW) - 32'd1);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    dith   = F'(lfsr_q & DitMask);
  end

  always_ff @(posedge clk_audio) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_comb dith = '0;
`endif

  always_comb begin
    tick          = (cnt_q == CntLast);
    xfer          = in_valid & in_ready_q;
    cnt_d         = tick ? '0 : cnt_q + CntW'(1);
    sample_tick_d = tick;
    pend_d        = xfer ? in_data : pend_q;
    // A tick always drains the buffer; a same-cycle transfer refills it.
    pend_full_d   = tick ? xfer : (pend_full_q | xfer);
    active_d      = (tick & pend_full_q) ? pend_q : active_q;
    in_ready_d    = ~pend_full_d;
    underrun_d    = underrun_q;
    if (tick & ~pend_full_q) underrun_d = 1'b1;
    if (clear_underrun)      underrun_d = 1'b0;
  end

  always_comb begin
    shifted = '0;
    g_w     = '0;
    u       = '0;
    sum     = '0;
    q_raw   = '0;
    dac_d   = '0;
    err_d   = '0;
    for (int unsigned k = 0; k < C_channels; k++) begin
      shifted[k] = $signed({{(GW - W){active_q[k*W + W - 1]}}, active_q[k*W +: W]}) <<< C_gain_shift;
      if ($signed(shifted[k]) > SatMax)      g_w[k] = SatMax[W-1:0];
      else if ($signed(shifted[k]) < SatMin) g_w[k] = SatMin[W-1:0];
      else                                   g_w[k] = shifted[k][W-1:0];
      // Two's complement to offset binary is an MSB flip.
      u[k]     = {~g_w[k][W-1], g_w[k][W-2:0]};
      sum[k]   = {1'b0, u[k]} + {{(W + 1 - F){1'b0}}, err_q[k]} + {{(W + 1 - F){1'b0}}, dith};
      q_raw[k] = sum[k][W:F];
      if (q_raw[k][Cw]) begin
        dac_d[k*Cw +: Cw] = '1;
        err_d[k]          = '1;
      end else begin
        dac_d[k*Cw +: Cw] = q_raw[k][Cw-1:0];
        err_d[k]          = sum[k][F-1:0] - dith;
      end
    end
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      pend_full_q   <= 1'b0;
      sample_tick_q <= 1'b0;
      underrun_q    <= 1'b0;
      pend_q        <= '0;
      active_q      <= '0;
      err_q         <= '0;
      dac_q         <= {C_channels{Mid}};
    end else begin
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      pend_full_q   <= pend_full_d;
      sample_tick_q <= sample_tick_d;
      underrun_q    <= underrun_d;
      pend_q        <= pend_d;
      active_q      <= active_d;
      err_q         <= err_d;
      dac_q         <= dac_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign sample_tick = sample_tick_q;
  assign underrun    = underrun_q;
  assign dac_out     = dac_q;

endmodule

// File: tb/tb_audio_dac_multibit.sv
// Bench for audio_dac_multibit: two instances (gain shift 0 and 2) against an arithmetic reference.
module tb_audio_dac_multibit;
  localparam int Div = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        clr;
  logic [31:0] in_data;
  logic        rdy, stk, und, rdy_g, stk_g, und_g;
  logic [7:0]  dac, dac_g;

  always #5 clk = ~clk;

  audio_dac_multibit #(
    .C_channels(2), .C_in_width(16), .C_out_width(4), .C_gain_shift(0), .C_div(Div)
  ) u_dut (
    .clk_audio(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy),
    .sample_tick(stk), .underrun(und), .clear_underrun(clr), .dac_out(dac)
  );

  audio_dac_multibit #(
    .C_channels(2), .C_in_width(16), .C_out_width(4), .C_gain_shift(2), .C_div(Div)
  ) u_dut_g (
    .clk_audio(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_g),
    .sample_tick(stk_g), .underrun(und_g), .clear_underrun(clr), .dac_out(dac_g)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: handshake bookkeeping plus per-instance, per-channel integrator.
  int          m_cnt;
  bit          m_full, m_ready, m_tick, m_under;
  logic [31:0] m_pend;
  int          m_act[2];
  int          m_err[2][2];
  int          m_dac[2][2];
  int          shift_of[2] = '{0, 2};

  typedef struct {
    logic [15:0] d0, d1;
    int          s0, s1, g0, g1;
  } vec_t;
  vec_t tbl[5];

  function automatic int offset_u(int s, int sh);
    int g;
    g = s * (1 << sh);
    if (g > 32767)  g = 32767;
    if (g < -32768) g = -32768;
    return g + 32768;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int old_act[2];
    int uu, sm, q;
    bit tk, xf;
    if (rst) begin
      m_cnt = 0; m_full = 0; m_ready = 0; m_tick = 0; m_under = 0;
      for (int c = 0; c < 2; c++) begin
        m_act[c] = 0;
        for (int i = 0; i < 2; i++) begin
          m_err[i][c] = 0;
          m_dac[i][c] = 8;
        end
      end
    end else begin
      old_act = m_act;
      tk = (m_cnt == Div - 1);
      xf = in_valid && m_ready;
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          uu = offset_u(old_act[c], shift_of[i]);
          sm = uu + m_err[i][c];
          q  = sm / 4096;
          if (q > 15) begin
            m_dac[i][c] = 15;
            m_err[i][c] = 4095;
          end else begin
            m_dac[i][c] = q;
            m_err[i][c] = sm % 4096;
          end
        end
      end
      m_under = clr ? 1'b0 : ((tk && !m_full) ? 1'b1 : m_under);
      if (tk && m_full) begin
        for (int c = 0; c < 2; c++) m_act[c] = int'($signed(m_pend[c*16 +: 16]));
      end
      m_full = tk ? xf : (m_full || xf);
      if (xf) m_pend = in_data;
      m_tick  = tk;
      m_cnt   = (m_cnt + 1) % Div;
      m_ready = !m_full;
    end
  endtask

  task automatic compare_all();
    check("dac", int'(dac), m_dac[0][0] + 16 * m_dac[0][1]);
    check("dac_gain", int'(dac_g), m_dac[1][0] + 16 * m_dac[1][1]);
    check("in_ready", int'(rdy), int'(m_ready));
    check("sample_tick", int'(stk), int'(m_tick));
    check("underrun", int'(und), int'(m_under));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_tick(string name);
    bit seen = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      cyc();
      if (stk) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: got no sample_tick, want one within 16 cycles", name);
    end
  endtask

  initial begin
    int s0, s1, g0, g1;
    tbl[0] = '{16'h7FFF, 16'h8000, 61440, 0,     61440, 0};
    tbl[1] = '{16'h0800, 16'h0000, 34816, 32768, 40960, 32768};
    tbl[2] = '{16'hF800, 16'h1234, 30720, 37428, 24576, 51408};
    tbl[3] = '{16'h4000, 16'hC000, 49152, 16384, 61440, 0};
    tbl[4] = '{16'h3000, 16'hF000, 45056, 28672, 61440, 16384};

    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; in_data = '0;
    repeat (3) cyc();
    check("rst_dac", int'(dac), 8'h88);
    check("rst_ready", int'(rdy), 0);
    check("rst_underrun", int'(und), 0);
    rst = 1'b0;
    cyc();
    check("ready_after_rst", int'(rdy), 1);

    // Single frame then starve the buffer.
    in_data = {16'h1234, 16'h0800}; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("ready_drop", int'(rdy), 0);
    wait_tick("first_tick");
    check("ready_after_tick", int'(rdy), 1);
    check("no_underrun_yet", int'(und), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("tick_gap", int'(stk), 0);
    end
    cyc();
    check("tick_period", int'(stk), 1);
    check("underrun_set", int'(und), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("underrun_clear", int'(und), 0);

    // Buffer full at the tick while the next frame is already offered.
    in_data = {16'h7FFF, 16'h7FFF}; in_valid = 1'b1;
    cyc();
    in_data = {16'h8000, 16'h8000};
    wait_tick("simul_tick1");
    cyc();
    check("simul_first", int'(dac), 8'hFF);
    wait_tick("simul_tick2");
    cyc();
    check("simul_second", int'(dac), 8'h00);
    check("simul_no_underrun", int'(und), 0);

    // Steady frames: 4096-cycle sum of codes equals the offset sample exactly unless clamped.
    foreach (tbl[n]) begin
      in_data = {tbl[n].d1, tbl[n].d0}; in_valid = 1'b1;
      repeat (16) cyc();
      s0 = 0; s1 = 0; g0 = 0; g1 = 0;
      for (int i = 0; i < 4096; i++) begin
        cyc();
        s0 += int'(dac[3:0]);   s1 += int'(dac[7:4]);
        g0 += int'(dac_g[3:0]); g1 += int'(dac_g[7:4]);
      end
      check($sformatf("avg_ch0_v%0d", n), s0, tbl[n].s0);
      check($sformatf("avg_ch1_v%0d", n), s1, tbl[n].s1);
      check($sformatf("avg_gain_ch0_v%0d", n), g0, tbl[n].g0);
      check($sformatf("avg_gain_ch1_v%0d", n), g1, tbl[n].g1);
    end

    // Random traffic against the reference.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      clr      = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
